// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
// Holds ALU opcodes, funct3 encodings, the FSM state encoding and the iteration count.
package alu_muldiv_pkg;

   localparam int         P_ITER    = 32;
   localparam logic [3:0] P_ALU_ADD = 4'b0000;
   localparam logic [3:0] P_ALU_SUB = 4'b1000;

   typedef enum logic [2:0] {
      F3_MUL    = 3'd0,
      F3_MULH   = 3'd1,
      F3_MULHSU = 3'd2,
      F3_MULHU  = 3'd3,
      F3_DIV    = 3'd4,
      F3_DIVU   = 3'd5,
      F3_REM    = 3'd6,
      F3_REMU   = 3'd7
   } funct3_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ITER  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU signals of the multiply/divide sequencer.
// The slave modport is the sequencer; the master side is execute stage plus ALU.
interface alu_muldiv_seq_if;

   logic        i_Start;
   logic [2:0]  i_Funct3;
   logic [31:0] i_OpA;
   logic [31:0] i_OpB;
   logic        i_Flush;
   logic        o_Busy;
   logic        o_Done;
   logic [31:0] o_Result;
   logic        o_AluOwn;
   logic [3:0]  o_AluOpCode;
   logic [31:0] o_AluSrcA;
   logic [31:0] o_AluSrcB;
   logic [31:0] i_AluResult;

   modport slave (
      input  i_Start, i_Funct3, i_OpA, i_OpB, i_Flush, i_AluResult,
      output o_Busy, o_Done, o_Result, o_AluOwn, o_AluOpCode, o_AluSrcA, o_AluSrcB
   );

   modport master (
      output i_Start, i_Funct3, i_OpA, i_OpB, i_Flush, i_AluResult,
      input  o_Busy, o_Done, o_Result, o_AluOwn, o_AluOpCode, o_AluSrcA, o_AluSrcB
   );

endinterface

// File: rtl/alu_muldiv_seq_sign_fix.sv
// Post-processing for the sequencer: conditional negate of the 64-bit product or of Q/R,
// then selection of the architectural result word.
module muldiv_sign_fix
   import alu_muldiv_pkg::*;
(
   input  funct3_e     i_Funct3,
   input  logic [31:0] i_Hi,
   input  logic [31:0] i_Lo,
   input  logic        i_NegRes,
   input  logic        i_NegRem,
   output logic [31:0] o_Word
);

   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // Hi/Lo hold the product for multiplies, and R/Q for divides.
   assign w_prod = i_NegRes ? (64'd0 - {i_Hi, i_Lo}) : {i_Hi, i_Lo};
   assign w_quot = i_NegRes ? (32'd0 - i_Lo) : i_Lo;
   assign w_rem  = i_NegRem ? (32'd0 - i_Hi) : i_Hi;

   always_comb begin
      o_Word = w_rem;
      case (i_Funct3)
         F3_MUL:                       o_Word = w_prod[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: o_Word = w_prod[63:32];
         F3_DIV, F3_DIVU:              o_Word = w_quot;
         default:                      o_Word = w_rem;
      endcase
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32M multiply/divide sequencer borrowing the shared 32-bit ALU for one ADD/SUB per step.
// Define MULDIV_FASTPATH_EN to resolve zero-operand and overflow cases directly in PREP.
module alu_muldiv_seq #(
   parameter int         P_ITER    = alu_muldiv_pkg::P_ITER,
   parameter logic [3:0] P_ALU_ADD = alu_muldiv_pkg::P_ALU_ADD,
   parameter logic [3:0] P_ALU_SUB = alu_muldiv_pkg::P_ALU_SUB
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   alu_muldiv_seq_if.slave    io_Bus
);

   import alu_muldiv_pkg::*;

   localparam int W_CNT = $clog2(P_ITER);

   state_e           r_state;
   state_e           w_next;
   funct3_e          r_funct;
   logic [31:0]      r_opa;
   logic [31:0]      r_opb;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_m;
   logic [31:0]      r_fix;
   logic [31:0]      r_result;
   logic [W_CNT-1:0] r_cnt;
   logic             r_neg_res;
   logic             r_neg_rem;

   logic        w_is_div;
   logic        w_a_signed;
   logic        w_b_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_div_s;
   logic        w_carry;
   logic        w_div_ge;
   logic [31:0] w_fix_word;
   logic        w_fast;
   logic [31:0] w_fast_val;

   assign w_is_div   = r_funct[2];
   assign w_a_signed = r_funct inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
   assign w_b_signed = r_funct inside {F3_MULH, F3_DIV, F3_REM};
   assign w_a_neg    = w_a_signed & r_opa[31];
   assign w_b_neg    = w_b_signed & r_opb[31];
   assign w_abs_a    = w_a_neg ? (32'd0 - r_opa) : r_opa;
   assign w_abs_b    = w_b_neg ? (32'd0 - r_opb) : r_opb;

   // Restoring-divide partial remainder is 33 bits; the ALU sees only its low word.
   assign w_div_s  = {r_hi, r_lo[31]};
   assign w_carry  = io_Bus.i_AluResult < r_hi;
   assign w_div_ge = w_div_s[32] | (w_div_s[31:0] >= r_m);

`ifdef MULDIV_FASTPATH_EN
   always_comb begin
      w_fast     = 1'b0;
      w_fast_val = '0;
      if (!w_is_div) begin
         w_fast = (r_opa == '0) || (r_opb == '0);
      end else if (r_opb == '0) begin
         w_fast     = 1'b1;
         w_fast_val = r_funct[1] ? r_opa : '1;
      end else if (w_a_signed && (r_opa == 32'h8000_0000) && (r_opb == '1)) begin
         w_fast     = 1'b1;
         w_fast_val = r_funct[1] ? '0 : 32'h8000_0000;
      end
   end
`else
   assign w_fast     = 1'b0;
   assign w_fast_val = '0;
`endif

   muldiv_sign_fix u_sign_fix (
      .i_Funct3 (r_funct),
      .i_Hi     (r_hi),
      .i_Lo     (r_lo),
      .i_NegRes (r_neg_res),
      .i_NegRem (r_neg_rem),
      .o_Word   (w_fix_word)
   );

   // NOTE: every output of a combinational block gets a default first, so no path
   // through the case/if tree can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (io_Bus.i_Start) w_next = ST_PREP;
         ST_PREP:  w_next = w_fast ? ST_DONE : ST_ITER;
         ST_ITER:  if (r_cnt == '0) w_next = ST_FIXUP;
         ST_FIXUP: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (io_Bus.i_Flush) w_next = ST_IDLE;
   end

   always_comb begin
      io_Bus.o_AluOwn    = 1'b0;
      io_Bus.o_AluOpCode = P_ALU_ADD;
      io_Bus.o_AluSrcA   = '0;
      io_Bus.o_AluSrcB   = '0;
      if (r_state == ST_ITER) begin
         io_Bus.o_AluOwn    = 1'b1;
         io_Bus.o_AluOpCode = w_is_div ? P_ALU_SUB : P_ALU_ADD;
         io_Bus.o_AluSrcA   = w_is_div ? w_div_s[31:0] : r_hi;
         io_Bus.o_AluSrcB   = r_m;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_funct   <= F3_MUL;
         r_opa     <= '0;
         r_opb     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_m       <= '0;
         r_fix     <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_next == ST_PREP) begin
                  r_funct <= funct3_e'(io_Bus.i_Funct3);
                  r_opa   <= io_Bus.i_OpA;
                  r_opb   <= io_Bus.i_OpB;
               end
            end
            ST_PREP: begin
               r_cnt <= W_CNT'(P_ITER - 1);
               r_fix <= w_fast_val;
               r_hi  <= '0;
               if (w_is_div) begin
                  r_lo      <= w_abs_a;
                  r_m       <= w_abs_b;
                  // A zero divisor must leave the all-ones quotient un-negated.
                  r_neg_res <= (w_a_neg ^ w_b_neg) & (r_opb != '0);
                  r_neg_rem <= w_a_neg;
               end else begin
                  r_lo      <= w_abs_b;
                  r_m       <= w_abs_a;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= 1'b0;
               end
            end
            ST_ITER: begin
               r_cnt <= r_cnt - W_CNT'(1);
               if (w_is_div) begin
                  r_hi <= w_div_ge ? io_Bus.i_AluResult : w_div_s[31:0];
                  r_lo <= {r_lo[30:0], w_div_ge};
               end else if (r_lo[0]) begin
                  r_hi <= {w_carry, io_Bus.i_AluResult[31:1]};
                  r_lo <= {io_Bus.i_AluResult[0], r_lo[31:1]};
               end else begin
                  r_hi <= {1'b0, r_hi[31:1]};
                  r_lo <= {r_hi[0], r_lo[31:1]};
               end
            end
            ST_FIXUP: r_fix <= w_fix_word;
            ST_DONE:  if (!io_Bus.i_Flush) r_result <= r_fix;
            default: ;
         endcase
      end
   end

   // A flush in DONE suppresses both the pulse and the visible result update.
   assign io_Bus.o_Busy   = (r_state != ST_IDLE);
   assign io_Bus.o_Done   = (r_state == ST_DONE) && !io_Bus.i_Flush;
   assign io_Bus.o_Result = io_Bus.o_Done ? r_fix : r_result;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M cases, random ops against an
// arithmetic reference model, flush, reset and start-while-busy scenarios.
module tb_alu_muldiv_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   alu_muldiv_seq_if bus ();

   // Shared combinational ALU that the sequencer borrows.
   assign bus.i_AluResult = (bus.o_AluOpCode == 4'b1000) ? (bus.o_AluSrcA - bus.o_AluSrcB)
                                                         : (bus.o_AluSrcA + bus.o_AluSrcB);

   alu_muldiv_seq dut (
      .i_Clk  (clk),
      .i_Rst  (rst),
      .io_Bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [14] = '{
      '{3'd0, 32'd7,          32'd6,          32'd42},
      '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h0},
      '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE},
      '{3'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF},
      '{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD},
      '{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF},
      '{3'd5, 32'd100,        32'd7,          32'd14},
      '{3'd7, 32'd100,        32'd7,          32'd2},
      '{3'd4, 32'd5,          32'd0,          32'hFFFFFFFF},
      '{3'd6, 32'd5,          32'd0,          32'd5},
      '{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000},
      '{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h0},
      '{3'd4, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF},
      '{3'd0, 32'd0,          32'd12345,      32'd0}
   };

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] ea, eb, p;
      logic [31:0] r;
      logic        ovf;
      ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p   = ea * eb;
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (f)
         3'd0:    r = p[31:0];
         3'd1, 3'd2, 3'd3: r = p[63:32];
         3'd4:    r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
         3'd5:    r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6:    r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit exp_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
      if (f < 3'd4) return (a == 0) || (b == 0);
      if (b == 0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
`else
      return 1'b0;
`endif
   endfunction

   // Issues one operation and watches it to completion plus a few idle cycles.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int own_cnt,
                         output int n_done, output bit alu_bad);
      res = 'x; lat = -1; own_cnt = 0; n_done = 0; alu_bad = 1'b0;
      @(negedge clk);
      bus.i_Start = 1'b1; bus.i_Funct3 = f; bus.i_OpA = a; bus.i_OpB = b;
      @(posedge clk);
      #1 bus.i_Start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (bus.o_AluOwn) begin
            own_cnt++;
            if (bus.o_AluOpCode !== (f[2] ? 4'b1000 : 4'b0000)) alu_bad = 1'b1;
         end else if (bus.o_AluOpCode !== 4'b0000 || bus.o_AluSrcA !== 0 || bus.o_AluSrcB !== 0) begin
            alu_bad = 1'b1;
         end
         if (bus.o_Done === 1'b1) begin
            n_done++;
            if (lat < 0) begin lat = k; res = bus.o_Result; end
         end
         if (lat > 0 && k >= lat + 3) break;
      end
   endtask

   task automatic check_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      logic [31:0] res;
      int lat, own, nd, exp_lat, exp_own;
      bit bad;
      exp_lat = exp_fast(f, a, b) ? 1 : 34;
      exp_own = exp_fast(f, a, b) ? 0 : 32;
      run_op(f, a, b, res, lat, own, nd, bad);
      n_vec++;
      if (res !== exp) begin
         n_err++;
         $display("FAIL %s result f=%0d a=%h b=%h got %h want %h", tag, f, a, b, res, exp);
      end
      n_vec++;
      if (lat !== exp_lat || nd !== 1) begin
         n_err++;
         $display("FAIL %s timing f=%0d latency got %0d want %0d, done pulses got %0d want 1", tag, f, lat, exp_lat, nd);
      end
      n_vec++;
      if (own !== exp_own || bad) begin
         n_err++;
         $display("FAIL %s alu_own f=%0d own cycles got %0d want %0d, bad opcode/operands %0d", tag, f, own, exp_own, bad);
      end
      n_vec++;
      if (bus.o_Result !== exp) begin
         n_err++;
         $display("FAIL %s result_hold got %h want %h", tag, bus.o_Result, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_vec++;
      if (bus.o_Busy !== 1'b0 || bus.o_Done !== 1'b0 || bus.o_AluOwn !== 1'b0 || bus.o_Result !== 0 ||
          bus.o_AluSrcA !== 0 || bus.o_AluSrcB !== 0 || bus.o_AluOpCode !== 4'b0000) begin
         n_err++;
         $display("FAIL %s outputs busy=%b done=%b own=%b res=%h a=%h b=%h op=%b want all zero",
                  tag, bus.o_Busy, bus.o_Done, bus.o_AluOwn, bus.o_Result, bus.o_AluSrcA,
                  bus.o_AluSrcB, bus.o_AluOpCode);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_directed();
      foreach (tbl[i]) check_op($sformatf("directed%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         check_op("random", f, a, b, ref_model(f, a, b));
      end
   endtask

   task automatic test_flush();
      logic [31:0] prior;
      bit saw_done;
      saw_done = 1'b0;
      check_op("flush_pre", 3'd3, 32'hDEADBEEF, 32'h12345678, ref_model(3'd3, 32'hDEADBEEF, 32'h12345678));
      prior = ref_model(3'd3, 32'hDEADBEEF, 32'h12345678);
      @(negedge clk);
      bus.i_Start = 1'b1; bus.i_Funct3 = 3'd4; bus.i_OpA = 32'd1000; bus.i_OpB = 32'd7;
      @(posedge clk);
      #1 bus.i_Start = 1'b0;
      repeat (9) begin @(posedge clk); #1 if (bus.o_Done) saw_done = 1'b1; end
      bus.i_Flush = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (bus.o_Busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_busy got %b want 0", bus.o_Busy);
      end
      bus.i_Flush = 1'b0;
      repeat (40) begin @(posedge clk); #1 if (bus.o_Done) saw_done = 1'b1; end
      n_vec++;
      if (saw_done || bus.o_Result !== prior) begin
         n_err++;
         $display("FAIL flush_no_done done_seen=%b result got %h want %h", saw_done, bus.o_Result, prior);
      end
      check_op("flush_post", 3'd4, 32'd1000, 32'd7, 32'd142);
   endtask

   task automatic test_flush_start_idle();
      @(negedge clk);
      bus.i_Start = 1'b1; bus.i_Flush = 1'b1; bus.i_Funct3 = 3'd0; bus.i_OpA = 3; bus.i_OpB = 4;
      @(posedge clk); #1;
      bus.i_Start = 1'b0; bus.i_Flush = 1'b0;
      n_vec++;
      if (bus.o_Busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_start_idle busy got %b want 0", bus.o_Busy);
      end
   endtask

   task automatic test_start_while_busy();
      int nd;
      logic [31:0] res;
      nd = 0; res = 'x;
      @(negedge clk);
      bus.i_Start = 1'b1; bus.i_Funct3 = 3'd0; bus.i_OpA = 32'd1234; bus.i_OpB = 32'd5678;
      @(posedge clk);
      #1 bus.i_Start = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 5) begin bus.i_Start = 1'b1; bus.i_Funct3 = 3'd5; bus.i_OpA = 99; bus.i_OpB = 3; end
         if (k == 8) bus.i_Start = 1'b0;
         @(posedge clk); #1;
         if (bus.o_Done) begin nd++; res = bus.o_Result; end
      end
      n_vec++;
      if (nd !== 1 || res !== 32'd7006652) begin
         n_err++;
         $display("FAIL busy_start done pulses got %0d want 1, result got %h want %h", nd, res, 32'd7006652);
      end
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      bus.i_Start = 1'b1; bus.i_Funct3 = 3'd1; bus.i_OpA = 32'h7654321; bus.i_OpB = 32'h89ABCDEF;
      @(posedge clk);
      #1 bus.i_Start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_idle_outputs("reset_mid");
      @(negedge clk) rst = 1'b0;
      repeat (45) begin @(posedge clk); #1 if (bus.o_Done) saw_done = 1'b1; end
      n_vec++;
      if (saw_done || bus.o_Result !== 0) begin
         n_err++;
         $display("FAIL reset_mid_no_done done_seen=%b result got %h want 0", saw_done, bus.o_Result);
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      bus.i_Start = 1'b0; bus.i_Funct3 = 3'd0; bus.i_OpA = '0; bus.i_OpB = '0; bus.i_Flush = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_flush_start_idle();
      test_start_while_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M MUL/DIV instructions, built on the shared combinational 32-bit ALU.
- Takes ownership of the ALU for one ADD or SUB per iteration (radix-2 shift-add multiply, restoring divide). Does sign pre/post-processing, shifts and carry/compare internally.
- Sits beside the execute stage. The execute-stage ALU operand mux selects this block's operands while o_AluOwn is high.

Parameters:
- P_ITER, 32, number of iteration cycles; equals the operand width, fixed at 32.
- P_ALU_ADD, 4'b0000, ALU opcode driven for multiply iterations.
- P_ALU_SUB, 4'b1000, ALU opcode driven for divide iterations.

Ports:
- i_Clk  in  1  clock; all state changes on the rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Start  in  1  request; sampled only in IDLE.
- i_Funct3  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU.
- i_OpA  in  32  rs1 (multiplicand / dividend).
- i_OpB  in  32  rs2 (multiplier / divisor).
- i_Flush  in  1  abort the current operation (pipeline flush).
- o_Busy  out  1  high in every non-IDLE state.
- o_Done  out  1  one-cycle pulse; o_Result valid in that cycle.
- o_Result  out  32  final result; held until the next accepted start.
- o_AluOwn  out  1  high only in ITER.
- o_AluOpCode  out  4  ALU opcode.
- o_AluSrcA  out  32  ALU operand A.
- o_AluSrcB  out  32  ALU operand B.
- i_AluResult  in  32  combinational ALU result, same cycle.

Behaviour:
- Reset (async, i_Rst=1): state=IDLE; o_Busy, o_Done, o_AluOwn, o_Result, o_AluSrcA, o_AluSrcB = 0; o_AluOpCode=P_ALU_ADD.
- Reset mid-operation: abandons immediately; no o_Done is issued.
- States: IDLE -> PREP -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE: i_Start=1 at edge T latches funct3 and operands, then goes to PREP. i_Start in any other state is ignored.
- PREP (T+1):
  - Signed operands (MULH/MULHSU rs1, MULH rs2, DIV/REM both) are replaced by their absolute values; the result sign is recorded.
  - Multiply: Hi=0, Lo=|B|, M=|A|.
  - Divide: R=0, Q=|A|, D=|B|.
  - Counter loaded with 31.
- ITER (T+2..T+33, exactly 32 cycles), multiply:
  - ALU drives ADD(Hi, M).
  - carry = (i_AluResult < Hi) unsigned.
  - If Lo[0]=1: {Hi,Lo} <= {carry, i_AluResult, Lo} >> 1; otherwise {Hi,Lo} <= {1'b0, Hi, Lo} >> 1.
- ITER, divide:
  - S = {R,Q[31]} as 33 bits; ALU drives SUB(S[31:0], D).
  - If S[32]=1 or S[31:0] >= D: R <= i_AluResult, shift in Q bit 1. Otherwise R <= S[31:0], shift in Q bit 0.
  - Q shifts left each cycle.
- ITER exits to FIXUP when the counter reaches 0.
- FIXUP (T+34):
  - Conditional 64-bit negate of the product, or negate of Q and/or R; internal logic, ALU not used.
  - Selects low word (MUL), high word (MULH*), Q or R.
  - DIV/REM sign rules: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- DONE (T+35): o_Done=1, o_Result updated, then IDLE at T+36.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend.
- Overflow (DIV/REM of 32'h80000000 by 32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0.
- The two special cases above are produced by the normal path unless the optional feature is enabled.
- i_Flush=1 in PREP/ITER/FIXUP/DONE: next state IDLE, no o_Done, o_Result unchanged.
- i_Flush and i_Start together in IDLE: flush wins, start is dropped.
- Outside ITER, o_AluSrcA/o_AluSrcB are 0 and o_AluOpCode is P_ALU_ADD.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined: PREP detects divide-by-zero, signed overflow, and multiply with either operand 0. It loads the architectural result directly and goes straight to DONE, so o_Done is at T+2 and o_AluOwn never asserts.
- Undefined: every operation takes the full 35-cycle latency. Result values are identical in both builds.

Decomposition:
- Package alu_muldiv_pkg: ALU opcode constants (ADD/SUB), funct3 encodings, state enum encoding, P_ITER.
- One sub-module, muldiv_sign_fix: combinational conditional negate of a 64-bit product or a 32-bit Q/R, plus word select; used in FIXUP.

Test Plan:
- MUL 7*6 -> o_Done at T+35, o_Result=42; o_AluOwn high exactly 32 cycles with o_AluOpCode=0000.
- MULH 32'hFFFFFFFF*32'hFFFFFFFF -> 0. MULHU same operands -> 32'hFFFFFFFE. MULHSU 32'hFFFFFFFF*2 -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD. REM -7/2 -> 32'hFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000. With MULDIV_FASTPATH_EN, done at T+2.
- Start DIV, assert i_Flush at T+10 -> o_Busy low at T+11, no o_Done, o_Result holds prior value. A new start at T+12 completes normally.
- Assert i_Rst asynchronously at T+20 mid-ITER -> all outputs 0 immediately. A second i_Start pulse while busy is ignored; exactly one o_Done per accepted start.
